// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: instruction word type and the
// {pc, inst, misalign} entry held in the decode-facing instruction queue.
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef logic [XLEN-1:0] inst_t;

    typedef struct packed {
        inst_t pc;
        inst_t inst;
        logic  misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with synchronous clear and occupancy count.
// Ports: clk, rst_n (async, active-low), push/wr_data, pop/rd_data,
//   clear, full, empty, count. DEPTH must be a power of 2.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: issues PCs to instruction memory, tags in-order responses
// with their PC and queues {pc, inst} for decode; flush drops everything.
// Ports: i_clk, i_rst_n (async, active-low), i_pc/i_pc_valid/o_pc_ready,
//   o_imem_req_valid/o_imem_addr/i_imem_req_ready, i_imem_rsp_valid/data,
//   i_flush, o_inst_valid/o_inst/o_inst_pc/i_inst_ready.
// Optional: FETCH_MISALIGN_CHK_EN adds o_inst_misalign; a misaligned PC
//   skips memory and queues a NOP flagged as misaligned.
module ifetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = fetch_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pc_valid,
    output logic            o_pc_ready,
    output logic            o_imem_req_valid,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    input  logic            i_flush,
    output logic            o_inst_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            o_inst_misalign,
`endif
    input  logic            i_inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Repeated flushes can stack more dropped responses than DEPTH.
    localparam int DW = CW + 4;

    logic          active;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] occ;
    logic [CW:0]   used;
    logic [DW-1:0] drop_cnt;
    logic [DW-1:0] outstanding;

    logic credit;
    logic open_slot;
    logic misalign;
    logic mis_pending;
    logic mis_done;
    logic accept;
    logic tag_push;
    logic rsp_live;
    logic rsp_take;
    logic q_push;
    logic q_pop;
    logic q_empty;

    inst_t        tag_pc;
    fetch_entry_t q_wr;
    fetch_entry_t q_rd;

    logic [CW-1:0] tag_cnt;
    logic          tag_full;
    logic          tag_empty;
    logic          q_full;
    logic          unused_status;

    assign unused_status = ^{tag_cnt, tag_full, tag_empty, q_full};

    // Outputs stay low until the first edge after reset release.
    assign used      = (CW+1)'(in_flight) + (CW+1)'(occ);
    assign credit    = active & (used < (CW+1)'(DEPTH));
    assign open_slot = credit & ~i_flush & ~mis_pending;

    assign o_pc_ready       = open_slot & (i_imem_req_ready | misalign);
    assign o_imem_req_valid = i_pc_valid & open_slot & ~misalign;
    assign o_imem_addr      = i_pc;

    assign accept   = i_pc_valid & o_pc_ready;
    assign tag_push = accept & ~misalign;

    // Responses owed to pre-flush requests are consumed by drop_cnt first.
    assign rsp_live    = i_imem_rsp_valid & (drop_cnt == '0)
                       & (in_flight != '0);
    assign rsp_take    = rsp_live & ~i_flush;
    assign outstanding = drop_cnt + DW'(in_flight);

    assign q_push = rsp_take | mis_done;
    assign q_pop  = o_inst_valid & i_inst_ready;

    assign o_inst_valid = ~q_empty;
    assign o_inst       = q_rd.inst;
    assign o_inst_pc    = q_rd.pc;

`ifdef FETCH_MISALIGN_CHK_EN
    inst_t mis_pc;

    assign misalign = |i_pc[1:0];
    // Further fetches wait behind a pending misaligned PC, so the NOP
    // enters only once every earlier memory response has landed.
    assign mis_done = mis_pending & (in_flight == '0) & ~i_flush;
    assign q_wr     = mis_done ? {mis_pc, NOP_INST, 1'b1}
                               : {tag_pc, i_imem_rsp_data, 1'b0};
    assign o_inst_misalign = q_rd.misalign;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mis_pending <= 1'b0;
            mis_pc      <= '0;
        end else if (i_flush | mis_done) begin
            mis_pending <= 1'b0;
        end else if (accept & misalign) begin
            mis_pending <= 1'b1;
            mis_pc      <= i_pc;
        end
    end
`else
    logic unused_misalign;

    assign misalign        = 1'b0;
    assign mis_pending     = 1'b0;
    assign mis_done        = 1'b0;
    assign q_wr            = {tag_pc, i_imem_rsp_data, 1'b0};
    assign unused_misalign = q_rd.misalign;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active    <= 1'b0;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            active <= 1'b1;
            if (i_flush) begin
                in_flight <= '0;
                // A response arriving now retires one of the outstanding.
                drop_cnt  <= outstanding
                           - DW'(i_imem_rsp_valid && outstanding != '0);
            end else begin
                in_flight <= in_flight + CW'(tag_push) - CW'(rsp_take);
                if (i_imem_rsp_valid && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (tag_push),
        .wr_data (i_pc),
        .pop     (rsp_take),
        .clear   (i_flush),
        .rd_data (tag_pc),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_cnt)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (q_push),
        .wr_data (q_wr),
        .pop     (q_pop),
        .clear   (i_flush),
        .rd_data (q_rd),
        .full    (q_full),
        .empty   (q_empty),
        .count   (occ)
    );

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_imem_rsp_valid && drop_cnt == '0) begin
            assert (in_flight != '0)
            else $error("ifetch_queue: response with nothing in flight");
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue against a request-level model:
// each outstanding fetch is live or killed, decode sees a simple queue.
module tb_ifetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        req_valid;
    logic [31:0] imem_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        flush = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        inst_mis;
`endif

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_pc             (pc),
        .i_pc_valid       (pc_valid),
        .o_pc_ready       (pc_ready),
        .o_imem_req_valid (req_valid),
        .o_imem_addr      (imem_addr),
        .i_imem_req_ready (req_ready),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_flush          (flush),
        .o_inst_valid     (inst_valid),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
`ifdef FETCH_MISALIGN_CHK_EN
        .o_inst_misalign  (inst_mis),
`endif
        .i_inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          due;
        bit          live;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          mis;
    } ent_t;

    req_t mq[$];
    ent_t iq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_due = 0;
    bit active = 0;
    bit mis_pend = 0;
    logic [31:0] mis_pc = '0;
    logic [31:0] next_pc = '0;

    int lat_min = 1, lat_max = 1;
    int p_valid = 100, p_rdy = 100, p_irdy = 100;
    int p_flush = 0, p_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int live_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i].live) n++;
        return n;
    endfunction

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        pc_valid = 1'b1;
        pc = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        flush = 1'b0;
        inst_ready = 1'b1;
        mq.delete();
        iq.delete();
        active = 0;
        mis_pend = 0;
        next_pc = '0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_pc_ready", 32'(pc_ready), 32'd0);
            chk("rst_req_valid", 32'(req_valid), 32'd0);
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            chk("rst_inst", inst, 32'd0);
            chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
            chk("rst_misalign", 32'(inst_mis), 32'd0);
`endif
            @(posedge clk);
            #1;
            cyc++;
        end
        last_due = cyc;
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        bit   mis, credit, exp_rdy, exp_req, acc, rsp, pop, mdone;
        int   lat, due;
        req_t r;
        ent_t e;
        pc_valid   = ($urandom_range(99) < p_valid);
        req_ready  = ($urandom_range(99) < p_rdy);
        inst_ready = ($urandom_range(99) < p_irdy);
        flush      = ($urandom_range(99) < p_flush);
        pc = next_pc;
        if ($urandom_range(99) < p_mis) pc = next_pc | 32'($urandom_range(3, 1));
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        rsp_valid = rsp;
        rsp_data  = rsp ? mq[0].data : $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
        mis = (pc[1:0] != 2'b00);
`else
        mis = 0;
`endif
        credit  = (live_cnt() + iq.size()) < DEPTH;
        exp_rdy = active && credit && !flush && !mis_pend && (req_ready || mis);
        exp_req = active && pc_valid && credit && !flush && !mis_pend && !mis;
        @(negedge clk);
        chk("pc_ready", 32'(pc_ready), 32'(exp_rdy));
        chk("req_valid", 32'(req_valid), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, pc);
        chk("inst_valid", 32'(inst_valid), 32'(iq.size() > 0));
        if (iq.size() > 0) begin
            chk("inst", inst, iq[0].inst);
            chk("inst_pc", inst_pc, iq[0].pc);
`ifdef FETCH_MISALIGN_CHK_EN
            chk("misalign", 32'(inst_mis), 32'(iq[0].mis));
`endif
        end
        acc   = pc_valid && exp_rdy;
        pop   = (iq.size() > 0) && inst_ready;
        mdone = mis_pend && (live_cnt() == 0) && !flush;
        if (rsp) r = mq.pop_front();
        if (flush) begin
            foreach (mq[i]) mq[i].live = 0;
            iq.delete();
            mis_pend = 0;
            next_pc = 32'h100;
        end else begin
            if (pop) void'(iq.pop_front());
            if (rsp && r.live) begin
                e = '{pc: r.pc, inst: r.data, mis: 0};
                iq.push_back(e);
            end
            if (mdone) begin
                e = '{pc: mis_pc, inst: 32'h13, mis: 1};
                iq.push_back(e);
                mis_pend = 0;
            end
            if (acc) begin
                if (mis) begin
                    mis_pend = 1;
                    mis_pc = pc;
                end else begin
                    lat = $urandom_range(lat_max, lat_min);
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    r = '{pc: pc, data: $urandom, due: due, live: 1};
                    mq.push_back(r);
                end
                next_pc = (pc & 32'hFFFF_FFFC) + 32'd4;
            end
        end
        @(posedge clk);
        if (rst_n) active = 1;
        cyc++;
        #1;
    endtask

    initial begin
        // reset with a valid PC pending, then stream from PC 0
        do_reset(3);
        lat_min = 1; lat_max = 1;
        p_valid = 100; p_rdy = 100; p_irdy = 100;
        repeat (20) cycle();
        // decode stalls: queue fills, then drains
        p_irdy = 0;
        repeat (10) cycle();
        p_irdy = 100;
        repeat (6) cycle();
        // slow memory with a redirect while fetches are in flight
        lat_min = 3; lat_max = 3;
        repeat (3) cycle();
        p_flush = 100;
        cycle();
        p_flush = 0;
        repeat (15) cycle();
        // flush landing on a response cycle
        lat_min = 1; lat_max = 2;
        repeat (4) cycle();
        p_flush = 100;
        cycle();
        p_flush = 0;
        repeat (10) cycle();
        // fully random traffic
        lat_min = 1; lat_max = 4;
        p_valid = 80; p_rdy = 70; p_irdy = 60; p_flush = 5;
        repeat (400) cycle();
        // reset in mid-operation
        do_reset(2);
        repeat (200) cycle();
`ifdef FETCH_MISALIGN_CHK_EN
        p_mis = 25;
        repeat (300) cycle();
        p_mis = 0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
